// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM port arbiter.
// Holds the default geometry of the shared memory, the requester count and
// the entry type carried down the read-response tracking pipeline.
package sram_arb_pkg;

    localparam int DEPTH        = 384;
    localparam int WIDTH        = 128;
    localparam int ADDR_BITS    = 9;
    localparam int READ_LATENCY = 1;
    localparam int NUM_REQ      = 2;

    // One tracking slot per cycle of read latency. A valid slot means a read
    // was accepted that many edges ago; err marks an out-of-range read that
    // never reached the memory and must answer with zero data.
    typedef struct packed {
        logic valid;
        logic id;
        logic err;
    } rsp_pipe_t;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin selection.
// Ports:
//   valid[1:0]  in   request present per requester
//   last_grant  in   requester granted on the most recent transfer
//   grant[1:0]  out  one-hot (or zero) grant
// A lone requester always wins; with both present, the one that did not win
// last time is chosen.
module sram_rr_pick (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] & (~valid[1] | last_grant);
        grant[1] = valid[1] & (~valid[0] | ~last_grant);
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two requesters onto a single-port SRAM.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready[1:0] per-requester request handshake
//   req_we[1:0]              1 = write, 0 = read
//   req_addr0/1, req_wdata0/1 per-requester address and write data
//   rsp_valid/rsp_err[1:0]   per-requester read response (no backpressure)
//   rsp_data                 shared read data, qualified by rsp_valid
//   sram_csb/sram_web        active-low chip select / write enable
//   sram_addr/sram_din       memory address and write data
//   sram_dout                memory read data
//
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both 1. req_ready is combinational from req_valid and the
// last grant, is never 1 for both requesters, and does not wait on anything
// else, so a requester may present a new request every cycle. Responses are
// delivered for exactly one cycle and cannot be stalled.
module sram_port_arbiter #(
    parameter int DEPTH        = sram_arb_pkg::DEPTH,
    parameter int WIDTH        = sram_arb_pkg::WIDTH,
    parameter int ADDR_BITS    = sram_arb_pkg::ADDR_BITS,
    parameter int READ_LATENCY = sram_arb_pkg::READ_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_we,
    input  logic [ADDR_BITS-1:0] req_addr0,
    input  logic [ADDR_BITS-1:0] req_addr1,
    input  logic [WIDTH-1:0]     req_wdata0,
    input  logic [WIDTH-1:0]     req_wdata1,
    output logic [1:0]           rsp_valid,
    output logic [1:0]           rsp_err,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 sram_csb,
    output logic                 sram_web,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [WIDTH-1:0]     sram_din,
    input  logic [WIDTH-1:0]     sram_dout
);

    import sram_arb_pkg::*;

    // One extra bit so DEPTH == 2**ADDR_BITS still compares correctly.
    localparam logic [ADDR_BITS:0] DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH);

    logic                 last_grant_q, last_grant_d;
    rsp_pipe_t            pipe_q [READ_LATENCY];
    rsp_pipe_t            pipe_d;
    rsp_pipe_t            pipe_out;

    logic [1:0]           grant;
    logic                 fire;
    logic                 gid;
    logic                 sel_we;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [WIDTH-1:0]     sel_wdata;
    logic                 in_range;

    sram_rr_pick u_pick (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // No acceptance at all while reset is held.
    assign req_ready = rst ? 2'b00 : grant;
    assign fire      = |req_ready;
    assign gid       = req_ready[1];

    assign sel_we    = gid ? req_we[1]  : req_we[0];
    assign sel_addr  = gid ? req_addr1  : req_addr0;
    assign sel_wdata = gid ? req_wdata1 : req_wdata0;
    assign in_range  = {1'b0, sel_addr} < DEPTH_LIM;

    // Out-of-range requests are accepted but the memory is left idle, so a
    // bad write is dropped and a bad read is answered from the pipeline alone.
    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        if (fire && in_range) begin
            sram_csb  = 1'b0;
            sram_web  = ~sel_we;
            sram_addr = sel_addr;
            sram_din  = sel_wdata;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (fire) begin
            last_grant_d = gid;
        end
        pipe_d       = '0;
        pipe_d.valid = fire & ~sel_we;
        pipe_d.id    = gid;
        pipe_d.err   = ~in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            pipe_q[0]    <= pipe_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // The last stage lines up with the memory's read data for that access.
    assign pipe_out = pipe_q[READ_LATENCY-1];

    always_comb begin
        rsp_valid = 2'b00;
        rsp_err   = 2'b00;
        rsp_data  = '0;
        if (!rst && pipe_out.valid) begin
            rsp_valid[pipe_out.id] = 1'b1;
            rsp_err[pipe_out.id]   = pipe_out.err;
            rsp_data               = pipe_out.err ? '0 : sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int W = 128;
  localparam int AB = 9;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_we;
  logic [AB-1:0] req_addr0, req_addr1;
  logic [W-1:0] req_wdata0, req_wdata1;
  logic [1:0] rsp_valid, rsp_err;
  logic [W-1:0] rsp_data;
  logic sram_csb, sram_web;
  logic [AB-1:0] sram_addr;
  logic [W-1:0] sram_din;
  logic [W-1:0] sram_dout;

  int vec_cnt = 0;
  int err_cnt = 0;

  // memory model: one-edge read latency, full 9-bit address space
  logic [W-1:0] mem [0:511];

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else sram_dout <= mem[sram_addr];
    end
  end

  function automatic logic [W-1:0] pat(input int a);
    return {32'hC0DE_0000 | 32'(a), 64'h0123_4567_89AB_CDEF, 32'(a * 5)};
  endfunction

  // driver tasks
  task automatic drive_idle();
    req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
  endtask

  // One request from one requester, then one idle cycle in which the
  // response (if any) is sampled.
  task automatic single_op(input int id, input logic we, input logic [AB-1:0] addr,
                           input logic [W-1:0] wd,
                           output logic [1:0] rdy, output logic csb, output logic web,
                           output logic [AB-1:0] sa, output logic [W-1:0] sd,
                           output logic [1:0] rv, output logic [1:0] re,
                           output logic [W-1:0] rd);
    @(negedge clk);
    drive_idle();
    req_valid[id] = 1'b1;
    req_we[id] = we;
    if (id == 0) begin req_addr0 = addr; req_wdata0 = wd; end
    else begin req_addr1 = addr; req_wdata1 = wd; end
    #1;
    rdy = req_ready; csb = sram_csb; web = sram_web; sa = sram_addr; sd = sram_din;
    @(negedge clk);
    drive_idle();
    #1;
    rv = rsp_valid; re = rsp_err; rd = rsp_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    vec_cnt++; if (req_ready !== 2'b00) begin err_cnt++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    vec_cnt++; if (sram_csb !== 1'b1) begin err_cnt++; $display("FAIL reset_csb: got %b want 1", sram_csb); end
    vec_cnt++; if (sram_web !== 1'b1) begin err_cnt++; $display("FAIL reset_web: got %b want 1", sram_web); end
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    vec_cnt++; if (rsp_err !== 2'b00) begin err_cnt++; $display("FAIL reset_rsp_err: got %b want 00", rsp_err); end
    vec_cnt++; if (rsp_data !== '0) begin err_cnt++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_addr0 = 9'd0; req_addr1 = 9'd128;
    #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL first_grant: got %b want 01", req_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rsp_valid !== 2'b01) begin err_cnt++; $display("FAIL first_rsp_valid: got %b want 01", rsp_valid); end
    vec_cnt++; if (rsp_data !== pat(0)) begin err_cnt++; $display("FAIL first_rsp_data: got %h want %h", rsp_data, pat(0)); end
  endtask

  task automatic test_contention();
    int i0, i1, n0, n1;
    logic [1:0] exp_g, prev_g;
    logic [AB-1:0] prev_a;
    i0 = 0; i1 = 0; n0 = 0; n1 = 0; prev_g = 2'b00; prev_a = '0;
    @(negedge clk); rst = 1'b1; drive_idle();
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      req_valid = 2'b11; req_we = 2'b00;
      req_addr0 = 9'(i0); req_addr1 = 9'(128 + i1);
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      vec_cnt++; if (req_ready !== exp_g) begin err_cnt++; $display("FAIL contention_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
      vec_cnt++; if (rsp_valid !== prev_g) begin err_cnt++; $display("FAIL contention_rsp_valid c=%0d: got %b want %b", c, rsp_valid, prev_g); end
      if (prev_g != 2'b00) begin
        vec_cnt++; if (rsp_data !== pat(int'(prev_a))) begin err_cnt++; $display("FAIL contention_rsp_data c=%0d: got %h want %h", c, rsp_data, pat(int'(prev_a))); end
      end
      if (rsp_valid[0]) n0++;
      if (rsp_valid[1]) n1++;
      prev_g = exp_g;
      prev_a = exp_g[0] ? 9'(i0) : 9'(128 + i1);
      if (exp_g[0]) i0++; else i1++;
    end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rsp_valid !== prev_g) begin err_cnt++; $display("FAIL contention_last_valid: got %b want %b", rsp_valid, prev_g); end
    vec_cnt++; if (rsp_data !== pat(int'(prev_a))) begin err_cnt++; $display("FAIL contention_last_data: got %h want %h", rsp_data, pat(int'(prev_a))); end
    if (rsp_valid[0]) n0++;
    if (rsp_valid[1]) n1++;
    vec_cnt++; if (n0 != 3 || n1 != 3) begin err_cnt++; $display("FAIL contention_counts: got %0d/%0d want 3/3", n0, n1); end
  endtask

  task automatic test_single_read();
    logic [1:0] rdy, rv, re; logic csb, web; logic [AB-1:0] sa; logic [W-1:0] sd, rd;
    single_op(0, 1'b1, 9'd5, 128'hA5, rdy, csb, web, sa, sd, rv, re, rd);
    vec_cnt++; if ({rdy, csb, web} !== 4'b0100) begin err_cnt++; $display("FAIL wr5_issue: got rdy=%b csb=%b web=%b want 01/0/0", rdy, csb, web); end
    vec_cnt++; if (sa !== 9'd5 || sd !== 128'hA5) begin err_cnt++; $display("FAIL wr5_bus: got addr=%0d din=%h want 5/a5", sa, sd); end
    vec_cnt++; if (rv !== 2'b00) begin err_cnt++; $display("FAIL wr5_no_rsp: got %b want 00", rv); end
    single_op(0, 1'b0, 9'd5, '0, rdy, csb, web, sa, sd, rv, re, rd);
    vec_cnt++; if ({rdy, csb, web} !== 4'b0101) begin err_cnt++; $display("FAIL rd5_issue: got rdy=%b csb=%b web=%b want 01/0/1", rdy, csb, web); end
    vec_cnt++; if (rv !== 2'b01 || re !== 2'b00) begin err_cnt++; $display("FAIL rd5_rsp: got v=%b e=%b want 01/00", rv, re); end
    vec_cnt++; if (rd !== 128'hA5) begin err_cnt++; $display("FAIL rd5_data: got %h want a5", rd); end
  endtask

  task automatic test_bank_crossing();
    logic [1:0] rdy, rv, re; logic csb, web; logic [AB-1:0] sa; logic [W-1:0] sd, rd;
    logic [AB-1:0] addrs [5];
    logic [W-1:0] expd;
    addrs = '{9'd127, 9'd128, 9'd255, 9'd256, 9'd383};
    for (int k = 0; k < 5; k++) begin
      expd = {32'hB000_0000 + 32'(k), 64'h0, 23'h0, addrs[k]};
      single_op(k % 2, 1'b1, addrs[k], expd, rdy, csb, web, sa, sd, rv, re, rd);
    end
    for (int k = 0; k < 5; k++) begin
      expd = {32'hB000_0000 + 32'(k), 64'h0, 23'h0, addrs[k]};
      single_op((k + 1) % 2, 1'b0, addrs[k], '0, rdy, csb, web, sa, sd, rv, re, rd);
      vec_cnt++; if (rv !== 2'(1 << ((k + 1) % 2)) || rd !== expd) begin err_cnt++; $display("FAIL bank_rd addr=%0d: got v=%b d=%h want d=%h", addrs[k], rv, rd, expd); end
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] rdy, rv, re; logic csb, web; logic [AB-1:0] sa; logic [W-1:0] sd, rd;
    single_op(0, 1'b0, 9'd384, '0, rdy, csb, web, sa, sd, rv, re, rd);
    vec_cnt++; if (rdy !== 2'b01 || csb !== 1'b1) begin err_cnt++; $display("FAIL oor_rd_issue: got rdy=%b csb=%b want 01/1", rdy, csb); end
    vec_cnt++; if (rv !== 2'b01 || re !== 2'b01 || rd !== '0) begin err_cnt++; $display("FAIL oor_rd_rsp: got v=%b e=%b d=%h want 01/01/0", rv, re, rd); end
    single_op(1, 1'b1, 9'd400, 128'hDEAD, rdy, csb, web, sa, sd, rv, re, rd);
    vec_cnt++; if (rdy !== 2'b10 || csb !== 1'b1 || rv !== 2'b00) begin err_cnt++; $display("FAIL oor_wr: got rdy=%b csb=%b v=%b want 10/1/00", rdy, csb, rv); end
    vec_cnt++; if (mem[400] !== pat(400)) begin err_cnt++; $display("FAIL oor_wr_mem: got %h want %h", mem[400], pat(400)); end
  endtask

  task automatic test_read_after_write();
    @(negedge clk);
    drive_idle();
    req_valid = 2'b10; req_we = 2'b10; req_addr1 = 9'd200; req_wdata1 = 128'h7777_0000_1234;
    @(negedge clk);
    drive_idle();
    req_valid = 2'b01; req_addr0 = 9'd200;
    #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL raw_ready: got %b want 01", req_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== 128'h7777_0000_1234) begin err_cnt++; $display("FAIL raw_data: got v=%b d=%h want 01/777700001234", rsp_valid, rsp_data); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive_idle();
    req_valid = 2'b01; req_addr0 = 9'd5;
    #1;
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL mid_ready: got %b want 01", req_ready); end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    vec_cnt++; if (rsp_valid !== 2'b00 || rsp_data !== '0) begin err_cnt++; $display("FAIL mid_rst_rsp: got v=%b d=%h want 00/0", rsp_valid, rsp_data); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11; req_addr0 = 9'd1; req_addr1 = 9'd129;
    #1;
    vec_cnt++; if (rsp_valid !== 2'b00) begin err_cnt++; $display("FAIL mid_post_rsp: got %b want 00", rsp_valid); end
    vec_cnt++; if (req_ready !== 2'b01) begin err_cnt++; $display("FAIL mid_post_grant: got %b want 01", req_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (rsp_valid !== 2'b01 || rsp_data !== pat(1)) begin err_cnt++; $display("FAIL mid_post_data: got v=%b d=%h want 01/%h", rsp_valid, rsp_data, pat(1)); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = pat(i);
    sram_dout = '0;
    test_reset();
    test_contention();
    test_single_read();
    test_bank_crossing();
    test_out_of_range();
    test_read_after_write();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
